// File: rtl/ddr_psctrl.sv
`timescale 1ns/1ps
// ddr_psctrl: handshake controller for the write-path DCM dynamic phase-shift
// port. Accepts inc/dec step requests, issues PSEN/PSINCDEC, waits for PSDONE
// (bounded by TIMEOUT cycles) and tracks the signed tap offset within
// +/-MAX_TAPS. Optional one-deep request queue: define DDR_PSCTRL_QUEUE_EN.
module ddr_psctrl #(
  parameter int MAX_TAPS = 255,
  parameter int TIMEOUT  = 1023,
  parameter int CNT_W    = 9
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dcm_locked,
  input  logic                    req_valid,
  input  logic                    req_inc,
  output logic                    req_ready,
  output logic                    psen,
  output logic                    psincdec,
  input  logic                    psdone,
  output logic signed [CNT_W-1:0] tap,
  output logic                    at_max,
  output logic                    at_min,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [CNT_W-1:0] TAP_MAX = CNT_W'(MAX_TAPS);
  localparam logic signed [CNT_W-1:0] TAP_MIN = -TAP_MAX;

  typedef enum logic [1:0] {
    S_UNLOCK,
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                    state, state_nxt;
  logic [TW-1:0]             wcnt, wcnt_nxt;
  logic                      psen_nxt, psincdec_nxt;
  logic signed [CNT_W-1:0]   tap_nxt, tap_step;
  logic                      at_max_nxt, at_min_nxt;
  logic                      busy_nxt, err_nxt;
  logic                      accept, step_done;

`ifdef DDR_PSCTRL_QUEUE_EN
  logic q_valid, q_valid_nxt;
  logic q_inc, q_inc_nxt;
  logic cand_valid, cand_inc;

  // Ready in IDLE, or in WAIT while the queue slot is free
  always_comb begin
    req_ready = dcm_locked & ((state == S_IDLE) | ((state == S_WAIT) & ~q_valid));
  end
`else
  // Ready only in IDLE with the DCM locked
  always_comb begin
    req_ready = dcm_locked & (state == S_IDLE);
  end
`endif

  // Next-state, step issue, tap arithmetic and timeout decode
  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    psen_nxt     = 1'b0;
    psincdec_nxt = psincdec;
    tap_nxt      = tap;
    at_max_nxt   = at_max;
    at_min_nxt   = at_min;
    err_nxt      = err_timeout;
    accept       = req_valid & req_ready;
    // psen is high only in the first WAIT cycle, so it doubles as the
    // "ignore psdone" marker
    step_done    = (state == S_WAIT) & ~psen & psdone;
    tap_step     = psincdec ? (tap + CNT_W'(1)) : (tap - CNT_W'(1));
`ifdef DDR_PSCTRL_QUEUE_EN
    q_valid_nxt  = q_valid;
    q_inc_nxt    = q_inc;
    cand_valid   = 1'b0;
    cand_inc     = 1'b0;
`endif

    if (!dcm_locked) begin
      state_nxt    = S_UNLOCK;
      tap_nxt      = '0;
      at_max_nxt   = 1'b0;
      at_min_nxt   = 1'b0;
      err_nxt      = 1'b0;
      psincdec_nxt = 1'b0;
`ifdef DDR_PSCTRL_QUEUE_EN
      q_valid_nxt  = 1'b0;
`endif
    end else begin
      case (state)
        S_UNLOCK: state_nxt = S_IDLE;
        S_IDLE: begin
          if (accept && !(req_inc ? at_max : at_min)) begin
            state_nxt    = S_WAIT;
            psen_nxt     = 1'b1;
            psincdec_nxt = req_inc;
            wcnt_nxt     = '0;
          end
        end
        S_WAIT: begin
          wcnt_nxt = wcnt + TW'(1);
`ifdef DDR_PSCTRL_QUEUE_EN
          if (accept) begin
            q_valid_nxt = 1'b1;
            q_inc_nxt   = req_inc;
          end
`endif
          if (step_done) begin
            tap_nxt    = tap_step;
            at_max_nxt = (tap_step == TAP_MAX);
            at_min_nxt = (tap_step == TAP_MIN);
            state_nxt  = S_IDLE;
`ifdef DDR_PSCTRL_QUEUE_EN
            // A request accepted on this very edge is chained like a queued one
            cand_valid  = q_valid | accept;
            cand_inc    = q_valid ? q_inc : req_inc;
            q_valid_nxt = 1'b0;
            if (cand_valid &&
                !(cand_inc ? (tap_step == TAP_MAX) : (tap_step == TAP_MIN))) begin
              state_nxt    = S_WAIT;
              psen_nxt     = 1'b1;
              psincdec_nxt = cand_inc;
              wcnt_nxt     = '0;
            end
`endif
          end else if (wcnt_nxt == TW'(TIMEOUT)) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
`ifdef DDR_PSCTRL_QUEUE_EN
            q_valid_nxt = 1'b0;
`endif
          end
        end
        default: state_nxt = S_UNLOCK;
      endcase
    end
    busy_nxt = (state_nxt == S_WAIT);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_UNLOCK;
      wcnt        <= '0;
      psen        <= 1'b0;
      psincdec    <= 1'b0;
      tap         <= '0;
      at_max      <= 1'b0;
      at_min      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      psen        <= psen_nxt;
      psincdec    <= psincdec_nxt;
      tap         <= tap_nxt;
      at_max      <= at_max_nxt;
      at_min      <= at_min_nxt;
      busy        <= busy_nxt;
      err_timeout <= err_nxt;
    end
  end

`ifdef DDR_PSCTRL_QUEUE_EN
  // One-deep request queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_valid <= 1'b0;
      q_inc   <= 1'b0;
    end else begin
      q_valid <= q_valid_nxt;
      q_inc   <= q_inc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_psctrl.sv
`timescale 1ns/1ps
// Testbench for ddr_psctrl: randomized and directed phase-shift steps, with a
// tap-offset reference model and a psen scoreboard monitor.
module tb_ddr_psctrl;

  localparam int MAX_TAPS = 255;
  localparam int TIMEOUT  = 1023;
  localparam int CNT_W    = 9;
`ifdef DDR_PSCTRL_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    dcm_locked;
  logic                    req_valid;
  logic                    req_inc;
  logic                    req_ready;
  logic                    psen;
  logic                    psincdec;
  logic                    psdone;
  logic signed [CNT_W-1:0] tap;
  logic                    at_max;
  logic                    at_min;
  logic                    busy;
  logic                    err_timeout;

  int checks   = 0;
  int failures = 0;
  int m_tap    = 0;
  bit m_err    = 1'b0;
  bit exp_q[$];

  ddr_psctrl #(
    .MAX_TAPS(MAX_TAPS),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dcm_locked (dcm_locked),
    .req_valid  (req_valid),
    .req_inc    (req_inc),
    .req_ready  (req_ready),
    .psen       (psen),
    .psincdec   (psincdec),
    .psdone     (psdone),
    .tap        (tap),
    .at_max     (at_max),
    .at_min     (at_min),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp_v, $time);
    end
  endfunction

  // Scoreboard monitor: every psen pulse must match the next expected step
  always @(negedge clk) begin
    if (reset_n && psen) begin
      chk("psen_pending", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) chk("psen_dir", psincdec, exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One request; d idle WAIT cycles before psdone; early adds psdone in the psen cycle
  task automatic do_step(input bit inc, input int d, input bit early);
    bit issue;
    issue = inc ? (m_tap < MAX_TAPS) : (m_tap > -MAX_TAPS);
    req_valid = 1'b1;
    req_inc   = inc;
    smp();
    chk("ready_idle", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    if (issue) exp_q.push_back(inc);
    smp();
    if (!issue) begin
      chk("drop_psen", psen, 0);
      chk("drop_busy", busy, 0);
      chk("drop_tap", tap, m_tap);
      cyc();
      return;
    end
    chk("wait_busy", busy, 1);
    chk("wait_psen", psen, 1);
    chk("wait_dir", psincdec, inc);
    chk("wait_ready", req_ready, QEN);
    if (early) psdone = 1'b1;
    cyc();
    psdone = 1'b0;
    for (int k = 0; k < d; k++) begin
      smp();
      chk("hold_busy", busy, 1);
      chk("hold_psen", psen, 0);
      chk("hold_dir", psincdec, inc);
      cyc();
    end
    psdone = 1'b1;
    smp();
    chk("done_busy", busy, 1);
    cyc();
    psdone = 1'b0;
    m_tap += inc ? 1 : -1;
    smp();
    chk("step_tap", tap, m_tap);
    chk("step_at_max", at_max, (m_tap == MAX_TAPS) ? 1 : 0);
    chk("step_at_min", at_min, (m_tap == -MAX_TAPS) ? 1 : 0);
    chk("step_busy", busy, 0);
    chk("step_psen", psen, 0);
    chk("step_ready", req_ready, 1);
    chk("step_err", err_timeout, m_err);
    cyc();
  endtask

  task automatic relock();
    dcm_locked = 1'b1;
    smp();
    chk("ready_unlock", req_ready, 0);
    cyc();
    smp();
    chk("ready_relock", req_ready, 1);
    cyc();
  endtask

  task automatic idle_lock_loss();
    dcm_locked = 1'b0;
    smp();
    chk("ll_ready_comb", req_ready, 0);
    cyc();
    smp();
    m_tap = 0;
    m_err = 1'b0;
    chk("ll_tap", tap, 0);
    chk("ll_err", err_timeout, 0);
    chk("ll_at_max", at_max, 0);
    chk("ll_at_min", at_min, 0);
    chk("ll_busy", busy, 0);
    cyc();
    relock();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    dcm_locked = 1'b1;
    req_valid  = 1'b0;
    req_inc    = 1'b0;
    psdone     = 1'b0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_tap", tap, 0);
    chk("rst_psen", psen, 0);
    chk("rst_psincdec", psincdec, 0);
    chk("rst_at_max", at_max, 0);
    chk("rst_at_min", at_min, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", req_ready, 0);
    cyc();
    reset_n = 1'b1;
    smp();
    chk("unlock_ready", req_ready, 0);
    cyc();
    smp();
    chk("idle_ready", req_ready, 1);
    cyc();

    // Single step and early psdone
    do_step(1'b1, 4, 1'b0);
    do_step(1'b0, 3, 1'b1);

    // Random walk
    for (int i = 0; i < 150; i++)
      do_step(1'($urandom_range(0, 1)), $urandom_range(0, 6), ($urandom_range(0, 7) == 0));

`ifdef DDR_PSCTRL_QUEUE_EN
    // Back-to-back requests: second one waits in the queue
    req_valid = 1'b1;
    req_inc   = 1'b1;
    cyc();
    exp_q.push_back(1'b1);
    req_inc = 1'b0;
    smp();
    chk("q_ready_empty", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    exp_q.push_back(1'b0);
    smp();
    chk("q_ready_full", req_ready, 0);
    psdone = 1'b1;
    cyc();
    psdone = 1'b0;
    m_tap += 1;
    smp();
    chk("q_psen", psen, 1);
    chk("q_dir", psincdec, 0);
    chk("q_busy", busy, 1);
    chk("q_tap1", tap, m_tap);
    cyc();
    psdone = 1'b1;
    smp();
    cyc();
    psdone = 1'b0;
    m_tap -= 1;
    smp();
    chk("q_tap2", tap, m_tap);
    chk("q_busy2", busy, 0);
    cyc();
`endif

    // Timeout: never answer psdone
    req_valid = 1'b1;
    req_inc   = 1'b1;
    cyc();
    req_valid = 1'b0;
    if (m_tap < MAX_TAPS) exp_q.push_back(1'b1);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      smp();
      if (!busy) break;
      n++;
      cyc();
    end
    m_err = 1'b1;
    chk("to_wait_cycles", n, TIMEOUT);
    chk("to_err", err_timeout, 1);
    chk("to_tap", tap, m_tap);
    chk("to_ready", req_ready, 1);
    cyc();
    do_step(1'b0, 1, 1'b0);

    // Lock loss in IDLE clears tap and the sticky error
    idle_lock_loss();

    // Lock loss mid-step at tap=7, coinciding with psdone
    for (int i = 0; i < 7; i++) do_step(1'b1, $urandom_range(0, 3), 1'b0);
    chk("pre_ll_tap", tap, 7);
    req_valid = 1'b1;
    req_inc   = 1'b1;
    cyc();
    req_valid = 1'b0;
    exp_q.push_back(1'b1);
    cyc();
    psdone     = 1'b1;
    dcm_locked = 1'b0;
    smp();
    chk("mid_busy", busy, 1);
    cyc();
    psdone = 1'b0;
    m_tap  = 0;
    smp();
    chk("mid_tap", tap, 0);
    chk("mid_psen", psen, 0);
    chk("mid_busy_off", busy, 0);
    chk("mid_ready", req_ready, 0);
    cyc();
    relock();

    // Positive saturation
    while (m_tap < MAX_TAPS) do_step(1'b1, 0, 1'b0);
    chk("sat_tap", tap, MAX_TAPS);
    chk("sat_at_max", at_max, 1);
    do_step(1'b1, 0, 1'b0);
    do_step(1'b0, 0, 1'b0);
    chk("sat_dec_tap", tap, MAX_TAPS - 1);

    // Negative saturation
    idle_lock_loss();
    while (m_tap > -MAX_TAPS) do_step(1'b0, 0, 1'b0);
    chk("satn_tap", tap, -MAX_TAPS);
    chk("satn_at_min", at_min, 1);
    do_step(1'b0, 0, 1'b0);
    do_step(1'b1, 0, 1'b0);
    chk("satn_inc_tap", tap, -MAX_TAPS + 1);

    repeat (2) cyc();
    chk("psen_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
